// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W      = 8;
    localparam int unsigned SPI_CNT_W       = 3;
    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'hFF;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset value.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic P_RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SPI_SYNC_STAGES-1:0] r_stages;

    // Shift the async input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stages <= {SPI_SYNC_STAGES{P_RESET_VAL}};
        end else begin
            r_stages <= {r_stages[SPI_SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with oversampled inputs and a single-entry transmit holding register.
module spi_slave
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_in,
    input  logic                  mosi_in,
    input  logic                  ss_in,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_w,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic [31:0]           debug
);

    logic w_s_sclk;
    logic w_s_mosi;
    logic w_s_ss;
    logic r_sclk_d;
    logic w_sclk_rise;
    logic w_sclk_fall;

    spi_state_t r_state;
    spi_state_t w_state_nxt;
    logic       w_load;
    logic       w_shift_tx;
    logic       w_rise_en;
    logic       w_clear_rx;

    logic [SPI_BYTE_W-1:0] r_shift_tx;
    logic [SPI_BYTE_W-1:0] r_shift_rx;
    logic [SPI_CNT_W-1:0]  r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic [SPI_BYTE_W-1:0] r_hold;
    logic                  r_hold_full;
    logic [SPI_BYTE_W-1:0] w_rx_next;

    // ss resets high so reset release never looks like a frame start.
    spi_sync #(.P_RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .i_d(sclk_in), .o_q(w_s_sclk));
    spi_sync #(.P_RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_d(mosi_in), .o_q(w_s_mosi));
    spi_sync #(.P_RESET_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .i_d(ss_in),   .o_q(w_s_ss));

    // Delayed copy of synced sclk for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d <= 1'b0;
        end else begin
            r_sclk_d <= w_s_sclk;
        end
    end

    assign w_sclk_rise = w_s_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_s_sclk & r_sclk_d;
    assign w_rx_next   = {r_shift_rx[SPI_BYTE_W-2:0], w_s_mosi};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SPI_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath enables; ss release overrides any sclk edge.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_tx  = 1'b0;
        w_rise_en   = 1'b0;
        w_clear_rx  = 1'b0;
        case (r_state)
            SPI_IDLE: begin
                if (!w_s_ss) begin
                    w_state_nxt = SPI_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                if (w_s_ss) begin
                    w_state_nxt = SPI_IDLE;
                    w_clear_rx  = 1'b1;
                end else begin
                    w_rise_en = w_sclk_rise;
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_load = 1'b1;
                        end else begin
                            w_shift_tx = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = SPI_IDLE;
        endcase
    end

    // Transmit shifter and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_tx  <= SPI_FILL_BYTE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift_tx <= r_hold_full ? r_hold : SPI_FILL_BYTE;
            end else if (w_shift_tx) begin
                r_shift_tx <= {r_shift_tx[SPI_BYTE_W-2:0], 1'b0};
            end
            // A write into an empty holder is kept for the following byte even if a load happens now.
            if (tx_w && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Receive shifter, bit counter and received-byte strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_rx <= '0;
            r_bit_cnt  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_clear_rx) begin
                r_shift_rx <= '0;
                r_bit_cnt  <= '0;
            end else if (w_rise_en) begin
                r_shift_rx <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + SPI_CNT_W'(1);
                if (r_bit_cnt == '1) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    assign miso     = r_shift_tx[SPI_BYTE_W-1];
    assign miso_oe  = (r_state == SPI_ACTIVE);
    assign busy     = (r_state == SPI_ACTIVE);
    assign tx_ready = ~r_hold_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign debug    = {r_shift_tx, r_shift_rx, r_rx_data, 5'b0, r_bit_cnt};

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged mode-0 master with an rx_valid monitor.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk_in;
    logic        mosi_in;
    logic        ss_in;
    logic        miso;
    logic        miso_oe;
    logic [7:0]  tx_data;
    logic        tx_w;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic [31:0] debug;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_rx[$];

    spi_slave dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .mosi_in(mosi_in), .ss_in(ss_in),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_w(tx_w),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .debug(debug)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_rx.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
                check("rx_byte", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tx_write(input logic [7:0] d);
        tx_data = d;
        tx_w    = 1'b1;
        @(negedge clk);
        tx_w    = 1'b0;
        @(negedge clk);
    endtask

    task automatic ss_low();
        ss_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (8) @(negedge clk);
        ss_in = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Mode-0 master: drive mosi while sclk low, sample miso just before the rising edge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit do_w,
                            input logic [7:0] wd, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_in = mo[7-i];
            repeat (8) @(negedge clk);
            mi = {mi[6:0], miso};
            sclk_in = 1'b1;
            if (do_w && i == 3) begin
                tx_data = wd;
                tx_w    = 1'b1;
                @(negedge clk);
                tx_w    = 1'b0;
                repeat (7) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            sclk_in = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] got;
        rst = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0; ss_in = 1'b1;
        tx_data = 8'h00; tx_w = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso",     {31'h0, miso},     32'h1);
        check("rst_miso_oe",  {31'h0, miso_oe},  32'h0);
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("rst_rx_data",  {24'h0, rx_data},  32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_busy",     {31'h0, busy},     32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Preloaded byte is sent; holder empties at frame start.
        tx_write(8'h3C);
        check("t1_ready_low", {31'h0, tx_ready}, 32'h0);
        ss_low();
        check("t1_busy",      {31'h0, busy},     32'h1);
        check("t1_oe",        {31'h0, miso_oe},  32'h1);
        check("t1_ready_hi",  {31'h0, tx_ready}, 32'h1);
        exp_rx.push_back(8'hA5);
        spi_bits(8'hA5, 8, 1'b0, 8'h00, got);
        check("t1_miso_byte", {24'h0, got}, 32'h3C);
        ss_high();
        check("t1_idle",      {31'h0, busy},     32'h0);
        check("t1_rx_held",   {24'h0, rx_data},  32'hA5);

        // Two-byte frame, write during byte 1 feeds byte 2.
        ss_low();
        exp_rx.push_back(8'h12);
        exp_rx.push_back(8'h34);
        spi_bits(8'h12, 8, 1'b1, 8'h56, got);
        check("t2_miso_b0", {24'h0, got}, 32'hFF);
        spi_bits(8'h34, 8, 1'b0, 8'h00, got);
        check("t2_miso_b1", {24'h0, got}, 32'h56);
        ss_high();

        // No write: fill byte.
        ss_low();
        exp_rx.push_back(8'h5A);
        spi_bits(8'h5A, 8, 1'b0, 8'h00, got);
        check("t3_miso_fill", {24'h0, got}, 32'hFF);
        ss_high();

        // Partial byte discarded, next frame clean.
        ss_low();
        spi_bits(8'hE7, 5, 1'b0, 8'h00, got);
        ss_high();
        check("t4_no_valid", {31'h0, rx_valid}, 32'h0);
        ss_low();
        exp_rx.push_back(8'h81);
        spi_bits(8'h81, 8, 1'b0, 8'h00, got);
        check("t4_miso", {24'h0, got}, 32'hFF);
        ss_high();

        // Second write while full is ignored.
        tx_write(8'h11);
        tx_write(8'h22);
        check("t5_ready_low", {31'h0, tx_ready}, 32'h0);
        ss_low();
        exp_rx.push_back(8'h00);
        spi_bits(8'h00, 8, 1'b0, 8'h00, got);
        check("t5_miso", {24'h0, got}, 32'h11);
        ss_high();
        check("t5_ready_hi", {31'h0, tx_ready}, 32'h1);

        // Reset mid-byte aborts the frame.
        tx_write(8'h99);
        ss_low();
        spi_bits(8'hF0, 4, 1'b0, 8'h00, got);
        rst   = 1'b1;
        ss_in = 1'b1;
        @(negedge clk);
        check("t6_miso",     {31'h0, miso},     32'h1);
        check("t6_miso_oe",  {31'h0, miso_oe},  32'h0);
        check("t6_tx_ready", {31'h0, tx_ready}, 32'h1);
        check("t6_rx_data",  {24'h0, rx_data},  32'h0);
        check("t6_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("t6_busy",     {31'h0, busy},     32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        ss_low();
        exp_rx.push_back(8'hC3);
        spi_bits(8'hC3, 8, 1'b0, 8'h00, got);
        check("t6_miso_fill", {24'h0, got}, 32'hFF);
        ss_high();
        check("t6_rx_held", {24'h0, rx_data}, 32'hC3);

        repeat (20) @(negedge clk);
        check("sb_drained", exp_rx.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 responder: the counterpart of the team's SPI master, used on test boards where the FPGA plays the device side of an SPI link (e.g. SD-card emulation or loopback against the master). All external SPI inputs are oversampled in the system clock domain. Each received byte is delivered with a one-cycle valid strobe. Transmit bytes come from a single-entry holding register, with 0xFF filled in whenever the holding register is empty.

## Interface
- no parameters; byte width fixed at 8
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sclk_in  in  1  SPI clock from master, asynchronous, idle low
- mosi_in  in  1  SPI data from master, asynchronous
- ss_in  in  1  SPI select from master, active low, asynchronous
- miso  out  1  SPI data to master, MSB first
- miso_oe  out  1  output enable for the miso pad; 1 while selected
- tx_data  in  8  next byte to transmit
- tx_w  in  1  write strobe for tx_data; accepted only when tx_ready=1
- tx_ready  out  1  holding register empty
- rx_data  out  8  last complete received byte; held until the next byte completes
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  frame in progress (state ACTIVE)
- debug  out  32  {shift_tx, shift_rx, rx_data, 5'b0, bit_cnt}

## Operation
- **Synchronizers**
  - sclk_in, mosi_in and ss_in each pass through 2 flip-flops.
  - Edge detection uses one further delayed copy of synced sclk.
  - sclk_rise = s_sclk & ~sclk_d; sclk_fall = ~s_sclk & sclk_d.
- **State IDLE** (synced ss=1)
  - miso_oe=0, bit_cnt=0.
  - On synced ss=0: shift_tx <= holding register if full, else 8'hFF; holding marked empty; go to ACTIVE.
- **State ACTIVE**
  - miso = shift_tx[7].
  - On sclk_rise:
    - shift_rx <= {shift_rx[6:0], s_mosi}.
    - bit_cnt <= bit_cnt+1, 3-bit, wraps 7->0.
    - If bit_cnt==7: rx_data <= {shift_rx[6:0], s_mosi} and rx_valid=1 on the next cycle.
  - On sclk_fall:
    - If bit_cnt==0 (byte boundary): load the next byte, with the same rule as frame start.
    - Otherwise: shift_tx <= {shift_tx[6:0], 1'b0}.
  - On synced ss=1: return to IDLE.
    - A partial byte is discarded: no rx_valid.
    - shift_rx and bit_cnt are cleared.
- **Holding register**
  - tx_w with tx_ready=1 stores tx_data.
  - tx_w with tx_ready=0 is ignored; the stored value is unchanged.
  - tx_w and a load in the same cycle:
    - Holding empty: the load takes 0xFF and tx_data is stored for the following byte.
    - Holding full: the load consumes the stored byte and tx_w is ignored.
- sclk_rise and ss release in the same cycle: ss wins; the edge is ignored.
- **Reset values**
  - Outputs: miso=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, state IDLE.
  - Synchronizers: ss sync stages reset to 1, sclk and mosi sync stages reset to 0, so no spurious edge or frame start.
  - Reset mid-frame aborts the frame. The next ss falling edge starts a clean frame.

## Timing
- Latency, sclk_in edge to internal edge pulse: 3 clk.
- rx_valid: asserted 4 clk after the sclk_in rising edge of bit 0 (LSB).
- miso change: 4 clk after an sclk_in falling edge. At frame start, miso is valid 4 clk after ss_in falls.
- Requirements on the master:
  - sclk half-period ≥ 6 clk, for miso setup before the master samples.
  - ss_in low ≥ 6 clk before the first sclk rise.
- tx_ready drops the cycle after an accepted tx_w and rises the cycle after a load.
- busy tracks state with no extra latency.

## Structure
- Shared package spi_pkg holds:
  - typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_state_t.
  - localparam SPI_FILL_BYTE = 8'hFF.
  - localparam SPI_SYNC_STAGES = 2.
- One sub-module, spi_sync: a 2-flop synchronizer with a reset-value parameter, instantiated 3 times.
- Everything else sits in the spi_slave body: shift registers, bit counter, holding register, FSM.

## Test plan
- Preload tx 0x3C, master sends 0xA5 -> one rx_valid pulse with rx_data=0xA5; master reads 0x3C; tx_ready=1 after the frame-start load.
- Two-byte frame with master data 0x12 then 0x34; tx 0x56 written during byte 1 -> rx_valid twice (0x12, 0x34); master reads first byte then 0x56.
- No tx write, one byte -> master reads 0xFF.
- ss_in released after 5 bits, then a new full frame with 0x81 -> no rx_valid for the partial byte; the next byte is 0x81.
- tx_w 0x11 then tx_w 0x22 before any frame -> master reads 0x11; the 0x22 write is ignored.
- rst asserted mid-byte -> all outputs at reset values the next cycle; the following frame with 0xC3 is received correctly.
